// File: rtl/risc_dmemory_sync.sv
// rtl/risc_dmemory_sync.sv - clocked data memory with busy/done handshake, wait states and reset-time clear
module risc_dmemory_sync #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dmenbl,
  input  logic              rdwr,
  input  logic [ADDR_W-1:0] dmaddr,
  input  logic [DATA_W-1:0] dmdatain,
  output logic [DATA_W-1:0] dmdataout,
  output logic              dmbusy,
  output logic              dmdone,
  output logic              dmerr
);

  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]        WS_LOAD   = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);
  localparam bit                NO_WAIT   = (WAIT_STATES == 0);

  logic [1:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic [3:0]        wcnt;
  logic              rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] dout_q;
  logic              err_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              commit;
  logic              c_rd;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_data;
  logic              c_ok;

  // With no wait states the commit happens on the acceptance edge, so the live inputs are used
  always_comb begin
    accept = (state == S_IDLE) && dmenbl;
    commit = (accept && NO_WAIT) || ((state == S_WAIT) && (wcnt == 4'd0));
    c_rd   = (state == S_IDLE) ? rdwr     : rd_q;
    c_addr = (state == S_IDLE) ? dmaddr   : addr_q;
    c_data = (state == S_IDLE) ? dmdatain : data_q;
    c_ok   = ({1'b0, c_addr} < DEPTH_L);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_INIT;
      cnt    <= '0;
      wcnt   <= '0;
      rd_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      dout_q <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ADDR) state <= S_IDLE;
        end
        S_IDLE: begin
          if (dmenbl) begin
            rd_q   <= rdwr;
            addr_q <= dmaddr;
            data_q <= dmdatain;
            wcnt   <= WS_LOAD;
            state  <= NO_WAIT ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (wcnt == 4'd0) state <= S_DONE;
          else              wcnt  <= wcnt - 4'd1;
        end
        default: state <= S_IDLE;
      endcase
      if (commit) begin
        err_q <= !c_ok;
        if (c_rd) dout_q <= c_ok ? mem[c_addr] : '0;
      end
    end
  end

  // Array has no reset; the INIT sweep clears it after every reset release
  always_ff @(posedge clk) begin
    if (state == S_INIT)
      mem[cnt] <= '0;
    else if (commit && !c_rd && c_ok)
      mem[c_addr] <= c_data;
  end

  assign dmdataout = dout_q;
  assign dmbusy    = (state != S_IDLE);
  assign dmdone    = (state == S_DONE);
  assign dmerr     = (state == S_DONE) && err_q;

endmodule

// File: doc/risc_dmemory_sync.md
Name: risc_dmemory_sync

Overview:
- Clocked, parametrised data memory for the RISC datapath. It services load and store requests from the control unit over a busy/done handshake.
- Word width, depth and access latency (wait states) are configurable.
- On reset, a hardware init sequencer clears the whole array.
- Out-of-range addresses are flagged and have no side effects.

Parameters:
- DATA_W, 8, bits per memory word
- DEPTH, 16, number of words (any value ≥ 2; need not be a power of two)
- ADDR_W, 4, address port width; must satisfy 2^ADDR_W ≥ DEPTH
- WAIT_STATES, 0, extra cycles between request acceptance and completion (0..15)

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- dmenbl  input  1  request strobe; sampled only when dmbusy=0
- rdwr  input  1  1 = read (load), 0 = write (store); captured at acceptance
- dmaddr  input  ADDR_W  word address; captured at acceptance
- dmdatain  input  DATA_W  store data; captured at acceptance
- dmdataout  output  DATA_W  registered load data
- dmbusy  output  1  high when no new request can be accepted
- dmdone  output  1  one-cycle completion pulse
- dmerr  output  1  address-error flag, valid only while dmdone=1

Behaviour:
- Reset (rst_n=0, async):
  - State goes to INIT; init counter = 0.
  - dmdataout = 0, dmdone = 0, dmerr = 0, dmbusy = 1.
  - Any in-flight request is discarded.
  - Array contents are undefined until INIT completes.
- INIT:
  - Writes 0 to word[cnt] each cycle; cnt increments 0..DEPTH-1.
  - After the edge writing word DEPTH-1, state goes to IDLE.
  - dmbusy stays 1 throughout. INIT lasts exactly DEPTH cycles after reset release.
  - dmenbl is ignored.
- IDLE:
  - dmbusy = 0.
  - If dmenbl=1 at a rising edge, the request is accepted: rdwr, dmaddr and dmdatain are latched.
  - Next state is WAIT if WAIT_STATES>0, else DONE. dmbusy rises on that same edge.
- WAIT:
  - Down-counter loaded with WAIT_STATES-1 at acceptance; decrements each cycle.
  - Moves to DONE on the edge where the counter is 0.
  - Exactly WAIT_STATES cycles are spent in WAIT.
- Entry edge into DONE (the commit edge):
  - Read, in range: dmdataout <= word[addr].
  - Write, in range: word[addr] <= data; dmdataout is unchanged.
  - Out of range (addr ≥ DEPTH): no array access; dmerr = 1; a read loads dmdataout with 0.
- DONE:
  - dmdone = 1 for exactly one cycle; dmbusy = 1.
  - Next state is IDLE. A new request can be accepted on the first IDLE edge.
- Latency:
  - Acceptance edge at cycle k → dmdone high in cycle k+1+WAIT_STATES.
  - Back-to-back throughput is one request per WAIT_STATES+2 cycles.
- dmdataout holds its value until the next successful or errored read commits. Writes never disturb it.
- dmenbl held high continuously: a new request is accepted at every IDLE edge. This is not an error.
- Inputs changing while dmbusy=1 have no effect; only the values latched at acceptance are used.
- Reset asserted mid-operation (WAIT or DONE):
  - A pending write that has not reached its commit edge is lost.
  - dmdone does not pulse.
  - INIT reruns and clears the whole array.
- Read-after-write to the same address returns the new data (the writes commit before the next acceptance).
- Array width is DATA_W. There is no byte masking; a write always replaces the full word.

Test Plan:
- Reset/init, DEPTH=16: release rst_n, then
  - dmbusy stays 1 for exactly 16 cycles and then falls;
  - reads of all 16 addresses return 0 with dmerr=0.
- Write/read, DATA_W=8, WAIT_STATES=0: write 8'hAA to address 5, then read address 5. The read's dmdone arrives 1 cycle after acceptance with dmdataout=8'hAA; a following write of 8'h11 to address 6 leaves dmdataout at 8'hAA.
- Wait states, WAIT_STATES=3: read accepted at edge k gives dmdone high only in cycle k+4; dmbusy=1 over cycles k+1..k+4. dmenbl held high throughout gives the next acceptance at edge k+5.
- Out of range, DEPTH=12, ADDR_W=4: write 8'h55 to address 13 completes with dmdone=1, dmerr=1. A read of address 13 returns 0 with dmerr=1; reads of addresses 0..11 remain 0 (no aliasing).
- Reset mid-op, WAIT_STATES=4: write 8'h77 to address 2, assert rst_n=0 in the 2nd WAIT cycle. Then:
  - dmdone never pulses;
  - init reruns;
  - a read of address 2 returns 0.
- Input hold, WAIT_STATES=2: after acceptance, change dmaddr, dmdatain and rdwr every cycle. Only the latched values take effect; verify by reading the target address and a decoy address.
